serial_add_ctrl: RTL and testbench
==================================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal range 1..32).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port start  input  1  request to begin an addition; sampled on clk.
REQ-005 SHALL have port a  input  WIDTH  operand A; captured when start is accepted.
REQ-006 SHALL have port b  input  WIDTH  operand B; captured when start is accepted.
REQ-007 SHALL have port cin  input  1  carry-in; captured when start is accepted.
REQ-008 SHALL have port busy  output  1  high while an addition is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse marking a valid result.
REQ-010 SHALL have port sum  output  WIDTH  registered result of a+b+cin, modulo 2^WIDTH.
REQ-011 SHALL have port cout  output  1  registered carry-out of the addition.

Function
REQ-012 SHALL implement FSM states IDLE, RUN and DONE.
REQ-013 In IDLE, start=1 at an edge SHALL be accepted: latch a, b and cin, clear bit counter, enter RUN.
REQ-014 start SHALL be ignored in RUN and DONE; a held start is not queued.
REQ-015 RUN SHALL process exactly one bit per cycle, LSB first, through a single full-adder instance.
REQ-016 Per RUN edge: partial-sum bit = A[i]^B[i]^carry, shifted in at the MSB end of the sum shift register; carry register updated to the full-adder carry; counter incremented.
REQ-017 On the edge that processes bit WIDTH-1, the FSM SHALL enter DONE and load sum/cout from the final shift register and carry.
REQ-018 Timing: start accepted at edge E0 -> busy=1 after E0 through EW; after EW done=1, busy=0; after E(W+1) done=0 and state IDLE.
REQ-019 Latency SHALL be WIDTH+1 cycles from start acceptance to done.
REQ-020 sum and cout SHALL change only on entry to DONE and SHALL hold until the next completed addition.
REQ-021 Operands changing on a/b/cin after acceptance SHALL NOT affect the result.
REQ-022 The bit counter SHALL be $clog2(WIDTH+1) bits and SHALL NOT wrap within an operation.
REQ-023 WIDTH=1 SHALL complete in one RUN cycle (done 2 cycles after acceptance).
REQ-024 A new start SHALL be accepted no earlier than the first edge in which the state is IDLE.

Reset
REQ-025 rst_n=0 SHALL immediately force state IDLE, busy=0, done=0, sum=0, cout=0, counter=0, carry=0 and operand registers=0.
REQ-026 Reset during RUN or DONE SHALL abort the operation; no done pulse SHALL follow.
REQ-027 After rst_n deasserts, the first edge with start=1 SHALL be accepted normally.

Structure
REQ-028 A shared package SHALL hold the default WIDTH constant and the FSM state type (IDLE, RUN, DONE).
REQ-029 The one-bit adder SHALL be the existing fulladd module (ports a, b, cin, sum, cout), instantiated once as the only sub-module.
REQ-030 All registers SHALL reside in serial_add_ctrl; fulladd stays purely combinational.

Verification
REQ-031 WIDTH=8, a=0x3C, b=0x5A, cin=0, start pulse -> done 9 cycles later, sum=0x96, cout=0.
REQ-032 WIDTH=8, a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-033 start held high for 20 cycles with a=0x01, b=0x02 -> result 0x03 at cycle 9, second acceptance on first IDLE edge, operands changed mid-RUN ignored.
REQ-034 rst_n low at cycle 4 of RUN -> outputs zero immediately, no done; a subsequent 0x10+0x20 -> sum=0x30, cout=0.
REQ-035 WIDTH=1, all 8 {a,b,cin} combinations -> sum/cout match full-adder truth table, done 2 cycles after each start.

Source files
------------

// File: rtl/serial_add_ctrl_pkg.sv
// Purpose: shared constants and FSM state type for the bit-serial adder.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
// Contents: DEFAULT_WIDTH (operand/result width), state_t (IDLE, RUN, DONE).
package serial_add_ctrl_pkg;

   // Operand/result width used when the parent does not override WIDTH.
   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/serial_add_ctrl_fulladd.sv
// Purpose: one-bit full adder, purely combinational.
// Latency: 0 cycles.
// Backpressure: none (no handshake, no state).
// Ports: a, b, cin -> sum = a^b^cin, cout = majority(a, b, cin).
module fulladd (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Purpose: bit-serial adder controller, computes a+b+cin one bit per cycle, LSB first.
// Latency: WIDTH+1 cycles from start acceptance to the done pulse.
// Backpressure: start is only accepted in IDLE; requests in RUN/DONE are dropped, not queued.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   start, a, b, cin  : request and operands, captured on the accepting edge
//   busy              : high while bits are being processed (RUN)
//   done              : one-cycle pulse while the result is fresh (DONE)
//   sum, cout         : registered result, held until the next completed addition
module serial_add_ctrl
   import serial_add_ctrl_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   // Counter is wide enough to hold WIDTH itself, so the final increment
   // never wraps back to zero inside an operation.
   localparam int              CNT_W    = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] sh_q, sh_d;
   logic [WIDTH-1:0] sum_d;
   logic             carry_q, carry_d;
   logic             cout_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             fa_sum;
   logic             fa_cout;

   // Operand registers shift right every RUN cycle, so the current bit is
   // always at position 0 and the adder never needs a variable index.
   fulladd u_fa (
      .a    (a_q[0]),
      .b    (b_q[0]),
      .cin  (carry_q),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sh_d    = sh_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      sum_d   = sum;
      cout_d  = cout;
      busy    = (state_q == RUN);
      done    = (state_q == DONE);

      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               carry_d = cin;
               cnt_d   = '0;
               sh_d    = '0;
               state_d = RUN;
            end
         end

         RUN: begin
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            carry_d = fa_cout;
            cnt_d   = cnt_q + CNT_ONE;
            // New bit enters at the MSB; after WIDTH shifts bit 0 of the
            // result has travelled down to position 0.
            sh_d    = (sh_q >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
            if (cnt_q == LAST_BIT) begin
               sum_d   = sh_d;
               cout_d  = fa_cout;
               state_d = DONE;
            end
         end

         DONE: begin
            // start is deliberately not looked at here; the earliest
            // re-acceptance is the first edge spent in IDLE.
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sh_q    <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         sum     <= '0;
         cout    <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sh_q    <= sh_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         sum     <= sum_d;
         cout    <= cout_d;
      end
   end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Purpose: self-checking bench for serial_add_ctrl at WIDTH=8 and WIDTH=1.
// Latency: expects done WIDTH+1 edges after start is driven (acceptance edge counted).
// Backpressure: exercises held start, mid-operation operand changes and mid-run reset.
module tb_serial_add_ctrl;

   logic       clk;
   logic       rst_n;

   logic       start8, cin8, busy8, done8, cout8;
   logic [7:0] a8, b8, sum8;

   logic       start1, cin1, busy1, done1, cout1;
   logic [0:0] a1, b1, sum1;

   int checks = 0;
   int errors = 0;

   logic [7:0] prev_sum8;
   logic       prev_cout8;
   logic       prev_sum1;
   logic       prev_cout1;

   serial_add_ctrl #(.WIDTH(8)) dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start8),
      .a     (a8),
      .b     (b8),
      .cin   (cin8),
      .busy  (busy8),
      .done  (done8),
      .sum   (sum8),
      .cout  (cout8)
   );

   serial_add_ctrl #(.WIDTH(1)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start1),
      .a     (a1),
      .b     (b1),
      .cin   (cin1),
      .busy  (busy1),
      .done  (done1),
      .sum   (sum1),
      .cout  (cout1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic [7:0] exp_sum;
      logic       exp_cout;
   } vec_t;

   vec_t v8 [9];
   vec_t v1 [8];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   function automatic logic [7:0] get_sum(input bit w1);
      return w1 ? {7'b0, sum1} : sum8;
   endfunction

   function automatic logic get_cout(input bit w1);
      return w1 ? cout1 : cout8;
   endfunction

   function automatic logic get_done(input bit w1);
      return w1 ? done1 : done8;
   endfunction

   function automatic logic get_busy(input bit w1);
      return w1 ? busy1 : busy8;
   endfunction

   // Called #1 after an edge with the selected DUT in IDLE. Drives one
   // start, scrambles operands right after acceptance, and checks latency,
   // result, pulse width and result hold.
   task automatic run_op(input bit w1, input logic [7:0] av, input logic [7:0] bv,
                         input logic cv, input logic [7:0] es, input logic ec,
                         input string nm);
      int         edges;
      bit         seen;
      int         exp_lat;
      logic [7:0] hold_sum;
      logic       hold_cout;
      exp_lat   = w1 ? 2 : 9;
      hold_sum  = w1 ? {7'b0, prev_sum1} : prev_sum8;
      hold_cout = w1 ? prev_cout1 : prev_cout8;
      if (w1) begin
         a1 = av[0:0]; b1 = bv[0:0]; cin1 = cv; start1 = 1'b1;
      end else begin
         a8 = av; b8 = bv; cin8 = cv; start8 = 1'b1;
      end
      @(posedge clk); #1;
      start1 = 1'b0; start8 = 1'b0;
      a8 = ~a8; b8 = ~b8; cin8 = ~cin8;
      a1 = ~a1; b1 = ~b1; cin1 = ~cin1;
      check({nm, " busy_after_accept"}, 32'(get_busy(w1)), 32'd1);
      check({nm, " sum_hold_in_run"}, 32'(get_sum(w1)), 32'(hold_sum));
      check({nm, " cout_hold_in_run"}, 32'(get_cout(w1)), 32'(hold_cout));
      edges = 1;
      seen  = 0;
      while (!seen && edges < 40) begin
         @(posedge clk); #1;
         edges++;
         if (get_done(w1)) seen = 1;
      end
      check({nm, " latency"}, 32'(edges), 32'(exp_lat));
      check({nm, " sum"}, 32'(get_sum(w1)), 32'(es));
      check({nm, " cout"}, 32'(get_cout(w1)), 32'(ec));
      check({nm, " busy_at_done"}, 32'(get_busy(w1)), 32'd0);
      @(posedge clk); #1;
      check({nm, " done_pulse_end"}, 32'(get_done(w1)), 32'd0);
      check({nm, " busy_idle"}, 32'(get_busy(w1)), 32'd0);
      check({nm, " sum_hold_after"}, 32'(get_sum(w1)), 32'(es));
      if (w1) begin
         prev_sum1 = es[0]; prev_cout1 = ec;
      end else begin
         prev_sum8 = es; prev_cout8 = ec;
      end
   endtask

   initial begin
      int ndone;

      v8[0] = '{8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0};
      v8[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
      v8[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
      v8[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
      v8[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
      v8[5] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};
      v8[6] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
      v8[7] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0};
      v8[8] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};

      v1[0] = '{8'h0, 8'h0, 1'b0, 8'h0, 1'b0};
      v1[1] = '{8'h0, 8'h0, 1'b1, 8'h1, 1'b0};
      v1[2] = '{8'h0, 8'h1, 1'b0, 8'h1, 1'b0};
      v1[3] = '{8'h0, 8'h1, 1'b1, 8'h0, 1'b1};
      v1[4] = '{8'h1, 8'h0, 1'b0, 8'h1, 1'b0};
      v1[5] = '{8'h1, 8'h0, 1'b1, 8'h0, 1'b1};
      v1[6] = '{8'h1, 8'h1, 1'b0, 8'h0, 1'b1};
      v1[7] = '{8'h1, 8'h1, 1'b1, 8'h1, 1'b1};

      rst_n  = 1'b0;
      start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
      start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
      prev_sum8 = '0; prev_cout8 = 1'b0; prev_sum1 = 1'b0; prev_cout1 = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      check("reset busy8", 32'(busy8), 32'd0);
      check("reset done8", 32'(done8), 32'd0);
      check("reset sum8", 32'(sum8), 32'd0);
      check("reset cout8", 32'(cout8), 32'd0);
      check("reset sum1", 32'(sum1), 32'd0);
      check("reset busy1", 32'(busy1), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 9; i++)
         run_op(1'b0, v8[i].a, v8[i].b, v8[i].cin, v8[i].exp_sum, v8[i].exp_cout,
                $sformatf("w8_vec%0d", i));

      for (int i = 0; i < 8; i++)
         run_op(1'b1, v1[i].a, v1[i].b, v1[i].cin, v1[i].exp_sum, v1[i].exp_cout,
                $sformatf("w1_vec%0d", i));

      // start held for 20 edges: first result 1+2, re-accept on the first
      // IDLE edge picks up the operands changed mid-run (F0+0F).
      start8 = 1'b1; a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0;
      ndone = 0;
      for (int n = 0; n < 30; n++) begin
         @(posedge clk); #1;
         if (n == 2) begin
            a8 = 8'hF0; b8 = 8'h0F;
         end
         if (n == 19) start8 = 1'b0;
         if (done8) begin
            ndone++;
            if (ndone == 1) begin
               check("held first_done_edge", 32'(n), 32'd8);
               check("held first_sum", 32'(sum8), 32'h03);
               check("held first_cout", 32'(cout8), 32'd0);
            end else begin
               check("held second_done_edge", 32'(n), 32'd18);
               check("held second_sum", 32'(sum8), 32'hFF);
               check("held second_cout", 32'(cout8), 32'd0);
            end
         end
         if (n == 9)  check("held idle_gap_busy", 32'(busy8), 32'd0);
         if (n == 10) check("held reaccept_busy", 32'(busy8), 32'd1);
      end
      check("held done_count", 32'(ndone), 32'd2);
      check("held end_busy", 32'(busy8), 32'd0);
      prev_sum8 = 8'hFF; prev_cout8 = 1'b0;

      // Reset in the fourth RUN cycle: outputs clear at once, no done follows.
      start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("abort busy_before_reset", 32'(busy8), 32'd1);
      rst_n = 1'b0;
      #1;
      check("abort busy8", 32'(busy8), 32'd0);
      check("abort done8", 32'(done8), 32'd0);
      check("abort sum8", 32'(sum8), 32'd0);
      check("abort cout8", 32'(cout8), 32'd0);
      check("abort sum1", 32'(sum1), 32'd0);
      check("abort cout1", 32'(cout1), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      ndone = 0;
      for (int n = 0; n < 12; n++) begin
         @(posedge clk); #1;
         if (done8 || busy8) ndone++;
      end
      check("abort no_done_after", 32'(ndone), 32'd0);
      prev_sum8 = 8'h00; prev_cout8 = 1'b0; prev_sum1 = 1'b0; prev_cout1 = 1'b0;

      run_op(1'b0, 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, "post_reset_w8");
      run_op(1'b1, 8'h1, 8'h1, 1'b0, 8'h0, 1'b1, "post_reset_w1");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
